ram_cmd_arbiter: RTL and testbench



---
 rtl/ram_cmd_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter that turns whole read/write transactions into
// SPI RAM address/data command beats. Optional feature macro: RAM_ADDR_REUSE_EN.
module ram_cmd_arbiter #(
    parameter int MEM_WIDTH  = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_wr,
    input  logic [2*MEM_WIDTH-1:0]   req_addr,
    input  logic [2*MEM_WIDTH-1:0]   req_wdata,
    output logic [1:0]               req_ready,
    output logic [1:0]               rsp_valid,
    output logic [MEM_WIDTH-1:0]     rsp_rdata,
    output logic                     rsp_err,
    output logic [MEM_WIDTH+1:0]     rx_data,
    output logic                     rx_valid,
    input  logic                     tx_valid,
    input  logic [MEM_WIDTH-1:0]     dout
);

    localparam logic [1:0] CTRL_WR_ADDR = 2'b00;
    localparam logic [1:0] CTRL_WR_DATA = 2'b01;
    localparam logic [1:0] CTRL_RD_ADDR = 2'b10;
    localparam logic [1:0] CTRL_RD_DATA = 2'b11;
    localparam logic [7:0] TO_LAST      = 8'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_WAIT_RD = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                 r_state, w_state_next;
    logic [1:0]             r_req_ready, w_req_ready_next;
    logic                   r_gnt, w_gnt_next;
    logic                   r_rr, w_rr_next;
    logic                   r_wr, w_wr_next;
    logic [MEM_WIDTH-1:0]   r_addr, w_addr_next;
    logic [MEM_WIDTH-1:0]   r_wdata, w_wdata_next;
    logic                   r_rx_valid, w_rx_valid_next;
    logic [MEM_WIDTH+1:0]   r_rx_data, w_rx_data_next;
    logic [1:0]             r_rsp_valid, w_rsp_valid_next;
    logic [MEM_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_next;
    logic                   r_rsp_err, w_rsp_err_next;
    logic [7:0]             r_cnt, w_cnt_next;

    logic [MEM_WIDTH-1:0]   w_req_addr  [2];
    logic [MEM_WIDTH-1:0]   w_req_wdata [2];
    logic                   w_arb_en;
    logic                   w_rr_eff;
    logic                   w_g;
    logic                   w_skip_addr;
    logic                   w_rd_timeout;
    logic [MEM_WIDTH+1:0]   w_addr_beat;
    logic [MEM_WIDTH+1:0]   w_data_beat;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign w_req_addr[gi]  = req_addr[gi*MEM_WIDTH +: MEM_WIDTH];
            assign w_req_wdata[gi] = req_wdata[gi*MEM_WIDTH +: MEM_WIDTH];
        end
    endgenerate

    // Arbitration also runs in RESP, where the pointer update (~gnt) is not yet visible.
    assign w_rr_eff     = (r_state == S_RESP) ? ~r_gnt : r_rr;
    assign w_g          = (&req_valid) ? w_rr_eff : req_valid[1];
    assign w_rd_timeout = (r_state == S_WAIT_RD) && !tx_valid && (r_cnt == TO_LAST);
    assign w_addr_beat  = {(r_wr ? CTRL_WR_ADDR : CTRL_RD_ADDR), r_addr};
    assign w_data_beat  = {(r_wr ? CTRL_WR_DATA : CTRL_RD_DATA), (r_wr ? r_wdata : '0)};

`ifdef RAM_ADDR_REUSE_EN
    logic [MEM_WIDTH-1:0]   r_last_wr_addr;
    logic [MEM_WIDTH-1:0]   r_last_rd_addr;
    logic                   r_last_wr_vld;
    logic                   r_last_rd_vld;

    assign w_skip_addr = r_wr ? (r_last_wr_vld && (r_last_wr_addr == r_addr))
                              : (r_last_rd_vld && (r_last_rd_addr == r_addr));

    // The RAM keeps separate write and read address latches, so track each kind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_wr_addr <= '0;
            r_last_rd_addr <= '0;
            r_last_wr_vld  <= 1'b0;
            r_last_rd_vld  <= 1'b0;
        end else begin
            if (r_state == S_ADDR) begin
                if (r_wr) begin
                    r_last_wr_addr <= r_addr;
                    r_last_wr_vld  <= 1'b1;
                end else begin
                    r_last_rd_addr <= r_addr;
                    r_last_rd_vld  <= 1'b1;
                end
            end
            if (w_rd_timeout) begin
                r_last_rd_vld <= 1'b0;
            end
        end
    end
`else
    assign w_skip_addr = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_req_ready_next = 2'b00;
        w_gnt_next       = r_gnt;
        w_rr_next        = r_rr;
        w_wr_next        = r_wr;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_rx_valid_next  = 1'b0;
        w_rx_data_next   = r_rx_data;
        w_rsp_valid_next = 2'b00;
        w_rsp_rdata_next = '0;
        w_rsp_err_next   = 1'b0;
        w_cnt_next       = '0;
        w_arb_en         = 1'b0;

        // Registered outputs are loaded on entry, so each state shows its own outputs.
        case (r_state)
            S_IDLE: begin
                if (r_req_ready != 2'b00) begin
                    w_rx_valid_next = 1'b1;
                    if (w_skip_addr) begin
                        w_state_next   = S_DATA;
                        w_rx_data_next = w_data_beat;
                    end else begin
                        w_state_next   = S_ADDR;
                        w_rx_data_next = w_addr_beat;
                    end
                end else begin
                    w_arb_en = 1'b1;
                end
            end
            S_ADDR: begin
                w_state_next    = S_DATA;
                w_rx_valid_next = 1'b1;
                w_rx_data_next  = w_data_beat;
            end
            S_DATA: begin
                if (r_wr) begin
                    w_state_next     = S_RESP;
                    w_rsp_valid_next = r_gnt ? 2'b10 : 2'b01;
                end else begin
                    w_state_next = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (tx_valid) begin
                    w_state_next     = S_RESP;
                    w_rsp_valid_next = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_rdata_next = dout;
                end else if (w_rd_timeout) begin
                    w_state_next     = S_RESP;
                    w_rsp_valid_next = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_err_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
                w_rr_next    = ~r_gnt;
                w_arb_en     = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_arb_en && (req_valid != 2'b00)) begin
            w_req_ready_next = w_g ? 2'b10 : 2'b01;
            w_gnt_next       = w_g;
            w_wr_next        = req_wr[w_g];
            w_addr_next      = w_req_addr[w_g];
            w_wdata_next     = w_req_wdata[w_g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 2'b00;
            r_gnt       <= 1'b0;
            r_rr        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= w_req_ready_next;
            r_gnt       <= w_gnt_next;
            r_rr        <= w_rr_next;
            r_wr        <= w_wr_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_rx_valid  <= w_rx_valid_next;
            r_rx_data   <= w_rx_data_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_err   <= w_rsp_err_next;
            r_cnt       <= w_cnt_next;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a 1-cycle behavioural SPI RAM attached.
module tb_ram_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic        ram_tx_valid;
    logic [7:0]  ram_dout;
    logic        ram_mute;

    int n_checks = 0;
    int n_fail   = 0;

    ram_cmd_arbiter #(.MEM_WIDTH(8), .RD_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_valid  (ram_tx_valid),
        .dout      (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: read data returns the cycle after the RD_DATA beat.
    logic [7:0] mem [256];
    logic [7:0] ram_wa, ram_ra;
    always @(posedge clk) begin
        if (!rst_n) begin
            ram_tx_valid <= 1'b0;
            ram_dout     <= 8'h00;
        end else begin
            ram_tx_valid <= 1'b0;
            if (rx_valid) begin
                case (rx_data[9:8])
                    2'b00: ram_wa <= rx_data[7:0];
                    2'b01: mem[ram_wa] <= rx_data[7:0];
                    2'b10: ram_ra <= rx_data[7:0];
                    default: begin
                        if (!ram_mute) begin
                            ram_tx_valid <= 1'b1;
                            ram_dout     <= mem[ram_ra];
                        end
                    end
                endcase
            end
        end
    end

    typedef struct packed {
        int         req;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       mute;
        int         nbeats;
        int         rsp_cyc;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    function automatic vec_t mk(input int req, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic mute, input int nb,
                                input int rc, input logic [7:0] rdata, input logic err);
        vec_t v;
        v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mute = mute;
        v.nbeats = nb; v.rsp_cyc = rc; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [9:0] b0, b1, exp_ab, exp_db;
        int         bc0, bc1, nb, rc;
        logic [1:0] rm;
        logic [7:0] rdat;
        logic       rerr;
        bit         got;
        b0 = '0; b1 = '0; bc0 = -1; bc1 = -1; nb = 0; rc = -1;
        rm = '0; rdat = '0; rerr = 1'b0; got = 1'b0;
        exp_ab = {(v.wr ? 2'b00 : 2'b10), v.addr};
        exp_db = {(v.wr ? 2'b01 : 2'b11), (v.wr ? v.wdata : 8'h00)};
        @(negedge clk);
        ram_mute = v.mute;
        req_valid = 2'b00;
        req_valid[v.req] = 1'b1;
        req_wr[v.req] = v.wr;
        req_addr[v.req*8 +: 8] = v.addr;
        req_wdata[v.req*8 +: 8] = v.wdata;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1'b1;
        end
        chk({nm, "_ready"}, {30'd0, req_ready}, 32'(1 << v.req));
        req_valid = 2'b00;
        if (!got) return;
        for (int k = 1; k <= 40 && rc < 0; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                if (nb == 0) begin b0 = rx_data; bc0 = k; end
                if (nb == 1) begin b1 = rx_data; bc1 = k; end
                nb++;
            end
            if (rsp_valid != 2'b00) begin
                rc = k; rm = rsp_valid; rdat = rsp_rdata; rerr = rsp_err;
            end
        end
        chk({nm, "_nbeats"}, nb, v.nbeats);
        if (v.nbeats == 2) begin
            chk({nm, "_addr_beat"}, {22'd0, b0}, {22'd0, exp_ab});
            chk({nm, "_addr_cyc"}, bc0, 1);
            chk({nm, "_data_beat"}, {22'd0, b1}, {22'd0, exp_db});
            chk({nm, "_data_cyc"}, bc1, 2);
        end else begin
            chk({nm, "_data_beat"}, {22'd0, b0}, {22'd0, exp_db});
            chk({nm, "_data_cyc"}, bc0, 1);
        end
        chk({nm, "_rsp_cyc"}, rc, v.rsp_cyc);
        chk({nm, "_rsp_mask"}, {30'd0, rm}, 32'(1 << v.req));
        chk({nm, "_rdata"}, {24'd0, rdat}, {24'd0, v.rdata});
        chk({nm, "_err"}, {31'd0, rerr}, {31'd0, v.err});
        $display("txn %s: req%0d %s addr=0x%02h beats=%0d rsp@%0d rdata=0x%02h err=%0d",
                 nm, v.req, v.wr ? "WR" : "RD", v.addr, nb, rc, rdat, rerr);
        ram_mute = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input logic [1:0] exp_mask);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) got = 1'b1;
        end
        chk({nm, "_rsp_mask"}, {30'd0, rsp_valid}, {30'd0, exp_mask});
    endtask

    vec_t vecs [8];
    vec_t vre  [4];

    initial begin
        int gidx [4];
        int gcyc [4];
        int gcnt, cyc, stray;
        bit got;

        vecs[0] = mk(0, 1'b1, 8'h12, 8'hA5, 1'b0, 2, 3,  8'h00, 1'b0);
        vecs[1] = mk(1, 1'b0, 8'h12, 8'h00, 1'b0, 2, 4,  8'hA5, 1'b0);
        vecs[2] = mk(0, 1'b0, 8'h34, 8'h00, 1'b1, 2, 18, 8'h00, 1'b1);
        vecs[3] = mk(1, 1'b1, 8'h34, 8'h5A, 1'b0, 2, 3,  8'h00, 1'b0);
        vecs[4] = mk(0, 1'b0, 8'h34, 8'h00, 1'b0, 2, 4,  8'h5A, 1'b0);
        vecs[5] = mk(1, 1'b0, 8'h12, 8'h00, 1'b0, 2, 4,  8'hA5, 1'b0);
        vecs[6] = mk(0, 1'b1, 8'hFF, 8'hC3, 1'b0, 2, 3,  8'h00, 1'b0);
        vecs[7] = mk(1, 1'b0, 8'hFF, 8'h00, 1'b0, 2, 4,  8'hC3, 1'b0);
        vre[0]  = mk(0, 1'b1, 8'h40, 8'h3C, 1'b0, 2, 3,  8'h00, 1'b0);
`ifdef RAM_ADDR_REUSE_EN
        vre[1]  = mk(0, 1'b1, 8'h40, 8'h96, 1'b0, 1, 2,  8'h00, 1'b0);
        vre[3]  = mk(1, 1'b0, 8'h40, 8'h00, 1'b0, 1, 3,  8'h96, 1'b0);
`else
        vre[1]  = mk(0, 1'b1, 8'h40, 8'h96, 1'b0, 2, 3,  8'h00, 1'b0);
        vre[3]  = mk(1, 1'b0, 8'h40, 8'h00, 1'b0, 2, 4,  8'h96, 1'b0);
`endif
        vre[2]  = mk(1, 1'b0, 8'h40, 8'h00, 1'b0, 2, 4,  8'h96, 1'b0);

        rst_n = 1'b0; req_valid = 2'b00; req_wr = 2'b00;
        req_addr = '0; req_wdata = '0; ram_mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 0);
        chk("rst_rx_valid",  {31'd0, rx_valid}, 0);
        chk("rst_rx_data",   {22'd0, rx_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_valid", {31'd0, rx_valid}, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Continuous dual write requests: grants must alternate every 4 cycles.
        @(negedge clk);
        req_wr = 2'b11; req_addr = {8'h61, 8'h60}; req_wdata = {8'h22, 8'h11};
        req_valid = 2'b11;
        gcnt = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin gidx[i] = -1; gcyc[i] = -1; end
        while (gcnt < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req_ready != 2'b00) begin
                chk("dual_ready_onehot", {30'd0, req_ready} & ({30'd0, req_ready} - 1), 0);
                gidx[gcnt] = req_ready[1] ? 1 : 0;
                gcyc[gcnt] = cyc;
                gcnt++;
            end
        end
        req_valid = 2'b00;
        chk("dual_grant_count", gcnt, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("dual_grant%0d", i), gidx[i], i % 2);
        for (int i = 0; i < 3; i++) chk($sformatf("dual_spacing%0d", i), gcyc[i+1] - gcyc[i], 4);
        $display("txn dual: grants %0d,%0d,%0d,%0d at cycles %0d,%0d,%0d,%0d",
                 gidx[0], gidx[1], gidx[2], gidx[3], gcyc[0], gcyc[1], gcyc[2], gcyc[3]);
        wait_rsp("dual_last", 2'b10);

        // Completed req0 transaction leaves rr=1; reset must bring it back to 0.
        run_vec(mk(0, 1'b1, 8'h80, 8'h11, 1'b0, 2, 3, 8'h00, 1'b0), "pre_reset");
        @(negedge clk);
        req_valid = 2'b10; req_wr[1] = 1'b0; req_addr[15:8] = 8'h12;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1'b1;
        end
        chk("rst_mid_ready", {30'd0, req_ready}, 2);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_mid_data_beat", {21'd0, rx_valid, rx_data}, {21'd0, 1'b1, 10'h300});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_rx_drop", {31'd0, rx_valid}, 0);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || rx_valid) stray++;
        end
        chk("rst_mid_no_rsp", stray, 0);
        $display("txn reset_mid_read: stray outputs after reset = %0d", stray);
        req_wr = 2'b11; req_addr = {8'h71, 8'h70}; req_wdata = {8'h44, 8'h33};
        req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1'b1;
        end
        chk("post_reset_grant", {30'd0, req_ready}, 1);
        req_valid = 2'b00;
        wait_rsp("post_reset", 2'b01);

        for (int i = 0; i < 4; i++) run_vec(vre[i], $sformatf("reuse%0d", i));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
